// File: rtl/keccak_arbiter.sv
// Round-robin arbiter sharing one keccak core between N_REQ requesters.
// A grant covers one whole job: the header, its input words and its output words.
module keccak_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W     = 64,
  parameter int unsigned CNT_W = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*W-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   rsp_valid_o,
  output logic [N_REQ*W-1:0] rsp_data_o,
  input  logic [N_REQ-1:0]   rsp_ready_i,
  output logic               core_valid_o,
  output logic [W-1:0]       core_data_o,
  input  logic               core_ready_i,
  input  logic               core_valid_i,
  input  logic [W-1:0]       core_data_i,
  output logic               core_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HEADER  = 2'd1;
  localparam logic [1:0] S_ABSORB  = 2'd2;
  localparam logic [1:0] S_SQUEEZE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic [W-1:0]     own_data;
  logic             own_valid;
  logic             own_rsp_ready;
  logic             in_phase;
  logic             out_phase;
  logic             in_hs;
  logic             out_hs;
  logic             done;
  logic [32:0]      in_sum;
  logic [32:0]      out_sum;
  logic [CNT_W-1:0] in_words;
  logic [CNT_W-1:0] out_words;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  // Owner selection is an AND-OR mux on the one-hot grant.
  always_comb begin
    own_data      = '0;
    own_valid     = |(req_valid_i & grant_q);
    own_rsp_ready = |(rsp_ready_i & grant_q);
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        own_data = own_data | req_data_i[i*W +: W];
      end
    end
  end

  always_comb begin
    in_phase     = (state_q == S_HEADER) || (state_q == S_ABSORB);
    out_phase    = (state_q == S_SQUEEZE);
    core_valid_o = in_phase & own_valid;
    core_data_o  = own_data;
    core_ready_o = out_phase & own_rsp_ready;
    req_ready_o  = (in_phase && core_ready_i) ? grant_q : '0;
    rsp_valid_o  = (out_phase && core_valid_i) ? grant_q : '0;
    rsp_data_o   = {N_REQ{core_data_i}};
    in_hs        = core_valid_o & core_ready_i;
    out_hs       = core_valid_i & core_ready_o;
    grant_o      = grant_q;
    busy_o       = (state_q != S_IDLE);
    in_sum       = {1'b0, own_data[31:0]} + 33'd7;
    out_sum      = {1'b0, own_data[63:32]} + 33'd7;
    in_words     = CNT_W'(in_sum >> 3);
    out_words    = CNT_W'(out_sum >> 3);
  end

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % N_REQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_d[i] = (pick_idx == IDX_W'(i));
          end
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        if (in_hs) begin
          in_cnt_d  = in_words;
          out_cnt_d = out_words;
          if (in_words != '0)       state_d = S_ABSORB;
          else if (out_words != '0) state_d = S_SQUEEZE;
          else                      done    = 1'b1;
        end
      end
      S_ABSORB: begin
        if (in_hs) begin
          in_cnt_d = in_cnt_q - 1'b1;
          if (in_cnt_q == CNT_W'(1)) begin
            if (out_cnt_q != '0) state_d = S_SQUEEZE;
            else                 done    = 1'b1;
          end
        end
      end
      default: begin
        if (out_hs) begin
          out_cnt_d = out_cnt_q - 1'b1;
          if (out_cnt_q == CNT_W'(1)) done = 1'b1;
        end
      end
    endcase
    // The freed owner drops to lowest priority for the next arbitration.
    if (done) begin
      state_d = S_IDLE;
      grant_d = '0;
      ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Scoreboard bench for keccak_arbiter: the bench plays both requesters and the core;
// expected core inputs, responses and grant order are queued at stimulus time.
module tb_keccak_arbiter;
  localparam int unsigned N = 2;
  localparam int unsigned W = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid_i = '0;
  logic [N*W-1:0] req_data_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   rsp_valid_o;
  logic [N*W-1:0] rsp_data_o;
  logic [N-1:0]   rsp_ready_i = '0;
  logic           core_valid_o;
  logic [W-1:0]   core_data_o;
  logic           core_ready_i = 1'b0;
  logic           core_valid_i = 1'b0;
  logic [W-1:0]   core_data_i = '0;
  logic           core_ready_o;
  logic [N-1:0]   grant_o;
  logic           busy_o;

  keccak_arbiter #(.N_REQ(2), .W(64), .CNT_W(30)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
    .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_ready_i(core_ready_i),
    .core_valid_i(core_valid_i), .core_data_i(core_data_i), .core_ready_o(core_ready_o),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  logic [63:0] req0_q[$], req1_q[$], core_src_q[$], exp_core_q[$], exp_rsp_q[$];
  int          exp_rsp_id_q[$];
  logic [1:0]  exp_grant_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int last_core_cyc = 0, last_rsp_cyc = 0, busy_fall_cyc = 0, rsp_seen = 0, idle_run = 1000;
  int r0_hs = 0, r1_hs = 0, core_hs = 0, r0_pop = 0, r1_pop = 0, core_pop = 0;
  int stall_cnt = 0;
  bit do_reset = 1'b1, bp = 1'b0, gap_chk = 1'b0;
  logic [1:0] prev_grant = '0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queues one job; nin/nout are hand-computed word counts for the lengths.
  task automatic push_job(input int r, input logic [31:0] in_len, input logic [31:0] out_len,
                          input int nin, input int nout, input logic [63:0] base);
    logic [63:0] w;
    w = {out_len, in_len};
    if (r == 0) req0_q.push_back(w); else req1_q.push_back(w);
    exp_core_q.push_back(w);
    for (int k = 0; k < nin; k++) begin
      w = base + 64'(k);
      if (r == 0) req0_q.push_back(w); else req1_q.push_back(w);
      exp_core_q.push_back(w);
    end
    for (int k = 0; k < nout; k++) begin
      w = base + 64'h80 + 64'(k);
      core_src_q.push_back(w);
      exp_rsp_q.push_back(w);
      exp_rsp_id_q.push_back(r);
    end
    exp_grant_q.push_back(r == 0 ? 2'b01 : 2'b10);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(req0_q.size() == 0 && req1_q.size() == 0 && exp_core_q.size() == 0 &&
             exp_rsp_q.size() == 0 && !busy_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("job_completes_in_budget", 64'(n >= budget), 64'd0);
    @(posedge clk);
  endtask

  task automatic wait_grant(input logic [1:0] g, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant_o != g && n < budget);
    chk("grant_seen_in_budget", 64'(grant_o), 64'(g));
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester/core driver: retires handshaken words, then presents queue heads.
  initial forever begin
    @(posedge clk);
    #1;
    while (r0_pop < r0_hs) begin if (req0_q.size() != 0) void'(req0_q.pop_front()); r0_pop++; end
    while (r1_pop < r1_hs) begin if (req1_q.size() != 0) void'(req1_q.pop_front()); r1_pop++; end
    while (core_pop < core_hs) begin if (core_src_q.size() != 0) void'(core_src_q.pop_front()); core_pop++; end
    if (do_reset) begin
      rst = 1'b1;
      req0_q.delete(); req1_q.delete(); core_src_q.delete();
      exp_core_q.delete(); exp_rsp_q.delete(); exp_rsp_id_q.delete();
      do_reset = 1'b0;
    end else begin
      rst = 1'b0;
    end
    req_valid_i[0]       = (req0_q.size() != 0);
    req_data_i[W-1:0]    = (req0_q.size() != 0) ? req0_q[0] : '0;
    req_valid_i[1]       = (req1_q.size() != 0);
    req_data_i[2*W-1:W]  = (req1_q.size() != 0) ? req1_q[0] : '0;
    core_valid_i         = (core_src_q.size() != 0);
    core_data_i          = (core_src_q.size() != 0) ? core_src_q[0] : '0;
    if (stall_cnt > 0) begin
      core_ready_i = 1'b0;
      rsp_ready_i  = '0;
      stall_cnt--;
    end else if (bp) begin
      core_ready_i = 1'($urandom_range(0, 1));
      rsp_ready_i  = 2'($urandom_range(0, 3));
    end else begin
      core_ready_i = 1'b1;
      rsp_ready_i  = '1;
    end
  end

  // Monitor: samples mid-cycle, pops the scoreboard on every handshake.
  initial forever begin
    logic [63:0] e;
    int id;
    @(negedge clk);
    if (!rst) begin
      checks++;
      if ($countones(grant_o) > 1 || (req_ready_o & ~grant_o) != 0 ||
          (rsp_valid_o & ~grant_o) != 0 || (core_valid_o && grant_o == '0)) begin
        errors++;
        $display("FAIL owner_only: grant=%b req_ready=%b rsp_valid=%b core_valid=%b, required activity on owner only",
                 grant_o, req_ready_o, rsp_valid_o, core_valid_o);
      end
      if (req_valid_i[0] && req_ready_o[0]) r0_hs++;
      if (req_valid_i[1] && req_ready_o[1]) r1_hs++;
      if (core_valid_i && core_ready_o) core_hs++;
      if (core_valid_o && core_ready_i) begin
        last_core_cyc = cyc;
        if (exp_core_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL core_in_unexpected: got %0h expected no word", core_data_o);
        end else begin
          e = exp_core_q.pop_front();
          chk("core_in_word", core_data_o, e);
        end
      end
      for (int r = 0; r < int'(N); r++) begin
        if (rsp_valid_o[r] && rsp_ready_i[r]) begin
          rsp_seen++;
          last_rsp_cyc = cyc;
          if (exp_rsp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: got %0h on %0d expected no word", rsp_data_o[r*W +: W], r);
          end else begin
            e  = exp_rsp_q.pop_front();
            id = exp_rsp_id_q.pop_front();
            chk("rsp_requester", 64'(r), 64'(id));
            chk("rsp_word", rsp_data_o[r*W +: W], e);
          end
        end
      end
      if (grant_o != '0 && prev_grant == '0) begin
        if (exp_grant_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL grant_unexpected: got %b expected none", grant_o);
        end else begin
          chk("grant_order", 64'(grant_o), 64'(exp_grant_q.pop_front()));
        end
        if (gap_chk) chk("idle_gap", 64'(idle_run), 64'd1);
      end
      if (grant_o == '0) idle_run++; else idle_run = 0;
      if (prev_busy && !busy_o) busy_fall_cyc = cyc;
    end
    prev_grant = grant_o;
    prev_busy  = busy_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int n;
    repeat (2) @(negedge clk);
    chk("reset_grant", 64'(grant_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_handshakes", {req_ready_o, rsp_valid_o, core_valid_o, core_ready_o}, 64'd0);
    @(posedge clk);

    // Contention: both requesters, two jobs each -> 0,1,0,1 with one idle cycle between.
    push_job(0, 8, 8, 1, 1, 64'h1000);
    push_job(1, 8, 8, 1, 1, 64'h2000);
    push_job(0, 8, 8, 1, 1, 64'h3000);
    push_job(1, 8, 8, 1, 1, 64'h4000);
    repeat (2) @(posedge clk);
    gap_chk = 1'b1;
    wait_done(300);
    gap_chk = 1'b0;

    // Single job on requester 0: header {32,20}, 3 in words, 4 out words.
    push_job(0, 20, 32, 3, 4, 64'h5000);
    @(negedge clk);
    chk("arb_cycle_no_grant", 64'(grant_o), 64'd0);
    chk("arb_cycle_no_ready", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    chk("grant_r0", 64'(grant_o), 64'd1);
    wait_done(200);
    chk("busy_falls_after_last_rsp", 64'(busy_fall_cyc), 64'(last_rsp_cyc + 1));

    // Zero lengths on requester 1; a pending core word must not be taken.
    seen = rsp_seen;
    push_job(1, 0, 0, 0, 0, 64'h6000);
    core_src_q.push_back(64'hDEAD_0000_0000_0001);
    wait_done(100);
    chk("zero_idle_after_header", 64'(busy_fall_cyc), 64'(last_core_cyc + 1));
    chk("zero_no_rsp", 64'(rsp_seen), 64'(seen));
    chk("zero_core_word_held", 64'(core_src_q.size()), 64'd1);
    core_src_q.delete();
    @(posedge clk);

    // Header {out=8, in=0}: straight to squeeze, one output word.
    seen = rsp_seen;
    push_job(0, 0, 8, 0, 1, 64'h7000);
    wait_done(100);
    chk("hdr_to_squeeze_rsp_count", 64'(rsp_seen - seen), 64'd1);
    chk("hdr_to_squeeze_timing", 64'(last_rsp_cyc), 64'(last_core_cyc + 1));

    // Rounding: in_len=1 -> 1 word, out_len=9 -> 2 words; a third core word stays stalled.
    push_job(1, 1, 9, 1, 2, 64'h8000);
    core_src_q.push_back(64'hDEAD_0000_0000_0002);
    wait_done(100);
    @(negedge clk);
    chk("round_third_word_stalled", {core_valid_i, core_ready_o}, 64'b10);
    chk("round_third_word_left", 64'(core_src_q.size()), 64'd1);
    @(posedge clk);
    core_src_q.delete();

    // Backpressure: requester 1 owns, a 5-cycle stall, then random readies; requester 0 waits.
    push_job(1, 40, 32, 5, 4, 64'h9000);
    wait_grant(2'b10, 20);
    stall_cnt = 5;
    bp = 1'b1;
    push_job(0, 8, 8, 1, 1, 64'hA000);
    wait_done(800);
    bp = 1'b0;

    // Reset after header + 2 of 5 input words; ptr must return to 0.
    push_job(0, 40, 0, 5, 0, 64'hB000);
    n = 0;
    while (exp_core_q.size() != 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("absorb_progress_in_budget", 64'(n >= 100), 64'd0);
    do_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_grant", 64'(grant_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_handshakes", {req_ready_o, rsp_valid_o, core_valid_o, core_ready_o}, 64'd0);
    @(posedge clk);
    push_job(0, 8, 8, 1, 1, 64'hC000);
    push_job(1, 8, 8, 1, 1, 64'hD000);
    wait_done(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
